// File: rtl/bus_ram_pkg.sv
// Shared types and constants for the bus-attached RAM peripheral.
// Latency: n/a (package only).
// Backpressure: n/a.
package bus_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Bit in a control-register write that starts a clear sweep.
  localparam int CTRL_CLR_BIT = 0;
  // Bit in the status readback that reflects BUSY.
  localparam int STATUS_BUSY_BIT = 0;

  // Window decode: the address bits above the array index must match the
  // base. Operands are zero-extended to 32 bits so one function serves any
  // bus width below that.
  function automatic logic win_hit(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input int          ram_aw);
    return (addr >> ram_aw) == (base >> ram_aw);
  endfunction

endpackage

// File: rtl/bus_ram_array.sv
// Single-port synchronous RAM with registered read data.
// Latency: read data valid one clock after re; writes land on the edge.
// Backpressure: none; accepts one access per clock.
// Ports: clk; we/idx/wdat write side; re strobes a read into rdat.
module bus_ram_array #(
  parameter int DATA_W     = 8,
  parameter int RAM_ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [RAM_ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0]     wdat,
  input  logic                  re,
  output logic [DATA_W-1:0]     rdat
);

  localparam int DEPTH = 1 << RAM_ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array or its output register so the tools can map
  // this onto block or distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdat;
    end
    if (re) begin
      rdat <= mem[idx];
    end
  end

endmodule

// File: rtl/bus_ram_ctrl.sv
// RAM peripheral on a shared tri-state bus with a hardware clear engine.
// Latency: reads (window or control register) drive BUS_DATA one clock after
//   the address is sampled; writes land on the sampling edge.
// Backpressure: none on the bus; during a clear sweep window accesses are
//   dropped (writes) or left undriven (reads), BUSY flags the sweep.
// Ports: CLK, RESET (async, active-high), BUS_DATA (inout), BUS_ADDR, BUS_WE,
//   BUSY (high while the array is being zero-filled).
module bus_ram_ctrl
  import bus_ram_pkg::*;
#(
  parameter int                 DATA_W     = 8,
  parameter int                 ADDR_W     = 8,
  parameter int                 RAM_ADDR_W = 7,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = 8'h00,
  parameter logic [ADDR_W-1:0]  CTRL_ADDR  = 8'hFF
) (
  input  logic              CLK,
  input  logic              RESET,
  inout  wire  [DATA_W-1:0] BUS_DATA,
  input  logic [ADDR_W-1:0] BUS_ADDR,
  input  logic              BUS_WE,
  output logic              BUSY
);

  localparam int                    DEPTH    = 1 << RAM_ADDR_W;
  localparam logic [RAM_ADDR_W-1:0] PTR_LAST = RAM_ADDR_W'(DEPTH - 1);

  state_t                  state, state_nxt;
  logic [RAM_ADDR_W-1:0]   ptr, ptr_nxt;
  logic                    oe, oe_nxt;
  logic                    sel_status, sel_status_nxt;
  logic [DATA_W-1:0]       status_q, status_nxt;
  logic [DATA_W-1:0]       ram_rdat;
  logic [DATA_W-1:0]       rd_data;

  logic                    hit_win, hit_ctrl, in_clear;
  logic                    rd_win, rd_ctrl;
  logic                    mem_we, mem_re;
  logic [RAM_ADDR_W-1:0]   mem_idx;
  logic [DATA_W-1:0]       mem_wdat;

  assign hit_win  = win_hit(32'(BUS_ADDR), 32'(BASE_ADDR), RAM_ADDR_W);
  assign hit_ctrl = (BUS_ADDR == CTRL_ADDR);
  assign in_clear = (state == CLEAR);
  assign BUSY     = in_clear;

  assign rd_win  = !BUS_WE && hit_win && !in_clear;
  assign rd_ctrl = !BUS_WE && hit_ctrl;

  // The sweep owns the array write port for its whole duration, so a bus
  // write can never collide with a clear write.
  assign mem_we   = in_clear || (BUS_WE && hit_win);
  assign mem_idx  = in_clear ? ptr : BUS_ADDR[RAM_ADDR_W-1:0];
  assign mem_wdat = in_clear ? '0 : BUS_DATA;
  assign mem_re   = rd_win;

  bus_ram_array #(
    .DATA_W     (DATA_W),
    .RAM_ADDR_W (RAM_ADDR_W)
  ) u_array (
    .clk  (CLK),
    .we   (mem_we),
    .idx  (mem_idx),
    .wdat (mem_wdat),
    .re   (mem_re),
    .rdat (ram_rdat)
  );

  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    oe_nxt         = rd_win || rd_ctrl;
    sel_status_nxt = sel_status;
    status_nxt     = status_q;

    case (state)
      CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == PTR_LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end
      end
      IDLE: begin
        if (BUS_WE && hit_ctrl && BUS_DATA[CTRL_CLR_BIT]) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase

    if (rd_ctrl) begin
      sel_status_nxt              = 1'b1;
      status_nxt                  = '0;
      status_nxt[STATUS_BUSY_BIT] = in_clear;
    end else if (rd_win) begin
      sel_status_nxt = 1'b0;
    end
  end

  // sel_status resets to 1 so the read-data mux presents the cleared
  // status register (all zeros) rather than the unreset RAM output.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= CLEAR;
      ptr        <= '0;
      oe         <= 1'b0;
      sel_status <= 1'b1;
      status_q   <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      oe         <= oe_nxt;
      sel_status <= sel_status_nxt;
      status_q   <= status_nxt;
    end
  end

  assign rd_data  = sel_status ? status_q : ram_rdat;
  assign BUS_DATA = oe ? rd_data : 'z;

endmodule

// File: tb/tb_bus_ram_ctrl.sv
// Directed bench for bus_ram_ctrl with a scoreboard of expected bus cycles.
// Each step drives one bus cycle and queues what the bus should show after
// the sampling edge; the entry is popped and compared one edge later.
module tb_bus_ram_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] BUS_ADDR = 8'h80;
  logic       BUS_WE = 1'b0;
  logic       BUSY;
  wire  [7:0] BUS_DATA;

  logic       tb_drv = 1'b0;
  logic [7:0] tb_dat = 8'h00;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic       drv;
    logic [7:0] dat;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  assign BUS_DATA = tb_drv ? tb_dat : 'z;

  always #5 CLK = ~CLK;

  bus_ram_ctrl dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .BUS_DATA (BUS_DATA),
    .BUS_ADDR (BUS_ADDR),
    .BUS_WE   (BUS_WE),
    .BUSY     (BUSY)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, queue expectation, clock, pop and compare.
  task automatic step(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                      input string tag, input logic exp_drv, input logic [7:0] exp_dat,
                      input logic exp_busy);
    exp_t e;
    BUS_WE   = we;
    BUS_ADDR = addr;
    tb_drv   = we;
    tb_dat   = wd;
    sb.push_back('{tag, exp_drv, exp_dat, exp_busy});
    @(posedge CLK);
    #1;
    tb_drv = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_oe"}, {7'd0, dut.oe}, {7'd0, e.drv});
    if (e.drv) check({e.tag, "_data"}, BUS_DATA, e.dat);
    check({e.tag, "_busy"}, {7'd0, BUSY}, {7'd0, e.busy});
  endtask

  // Polls status across a whole sweep: reads sampled on edges 1..128 see
  // BUSY=1, edge 129 sees 0; BUSY itself drops right after edge 128.
  task automatic poll_sweep(input string tag);
    for (int i = 1; i <= 129; i++) begin
      step(1'b0, 8'hFF, 8'h00, tag, 1'b1, (i <= 128) ? 8'h01 : 8'h00, i < 128);
    end
  endtask

  initial begin
    // Reset state.
    #3;
    check("rst_busy", {7'd0, BUSY}, 8'h01);
    check("rst_oe", {7'd0, dut.oe}, 8'h00);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Sweep after reset release lasts exactly 128 cycles.
    poll_sweep("init_poll");

    // Writes then back-to-back reads.
    step(1'b0, 8'h80, 8'h00, "idle0", 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h03, 8'h09, "wr03", 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h7F, 8'hA5, "wr7f", 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h03, 8'h00, "rd03", 1'b1, 8'h09, 1'b0);
    step(1'b0, 8'h7F, 8'h00, "rd7f", 1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h02, 8'h00, "rd02", 1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h80, 8'h00, "float_after", 1'b0, 8'h00, 1'b0);

    // Outside-window accesses and no aliasing onto offset 0.
    step(1'b0, 8'h80, 8'h00, "rd80", 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h80, 8'h55, "wr80", 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, "rd00", 1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h80, 8'h00, "idle1", 1'b0, 8'h00, 1'b0);

    // Software clear with accesses during the sweep.
    step(1'b1, 8'hFF, 8'h01, "clr_cmd", 1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 128; i++) begin
      case (i)
        50:      step(1'b1, 8'hFF, 8'h01, "sw_ctrl_wr", 1'b0, 8'h00, 1'b1);
        51:      step(1'b0, 8'hFF, 8'h00, "sw_ctrl_rd", 1'b1, 8'h01, 1'b1);
        100:     step(1'b1, 8'h10, 8'h77, "sw_wr10", 1'b0, 8'h00, 1'b1);
        101:     step(1'b0, 8'h10, 8'h00, "sw_rd10", 1'b0, 8'h00, 1'b1);
        default: step(1'b0, 8'h80, 8'h00, "sw_idle", 1'b0, 8'h00, i < 128);
      endcase
    end
    step(1'b0, 8'h10, 8'h00, "post_rd10", 1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h03, 8'h00, "post_rd03", 1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h7F, 8'h00, "post_rd7f", 1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h80, 8'h00, "idle2", 1'b0, 8'h00, 1'b0);

    // Reset in the middle of a sweep, while a status read is on the bus.
    step(1'b1, 8'hFF, 8'h01, "clr_cmd2", 1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 59; i++) begin
      step(1'b0, 8'h80, 8'h00, "sw2_idle", 1'b0, 8'h00, 1'b1);
    end
    step(1'b0, 8'hFF, 8'h00, "sw2_ctrl_rd", 1'b1, 8'h01, 1'b1);
    RESET = 1'b1;
    #1;
    check("midrst_oe", {7'd0, dut.oe}, 8'h00);
    check("midrst_busy", {7'd0, BUSY}, 8'h01);
    BUS_ADDR = 8'h80;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    poll_sweep("rst_poll");

    // Control write with the clear bit low does nothing.
    step(1'b0, 8'h80, 8'h00, "idle3", 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h03, 8'h5A, "wr03b", 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hFF, 8'h00, "ctrl_nop", 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h80, 8'h00, "nop_idle", 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h03, 8'h00, "rd03b", 1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'hFF, 8'h00, "rd_status", 1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h80, 8'h00, "idle4", 1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_ram_ctrl.md
Name: bus_ram_ctrl

Overview:
Parametrised RAM peripheral for the shared microprocessor bus: tri-state data, address and write-enable. It decodes its own address window, gives registered reads with 1-cycle latency, and writes on the clock edge. A hardware clear engine zero-fills the array after reset or on software command. A status/control register at a separate bus address exposes BUSY.

Parameters:
DATA_W, 8, bus and memory word width
ADDR_W, 8, bus address width
RAM_ADDR_W, 7, array index width; DEPTH = 2**RAM_ADDR_W (128)
BASE_ADDR, 8'h00, window base; must be DEPTH-aligned
CTRL_ADDR, 8'hFF, control/status register address; must lie outside the window

Ports:
CLK  in  1  system clock; all state changes on the rising edge
RESET  in  1  asynchronous, active-high reset
BUS_DATA  inout  DATA_W  shared tri-state data bus
BUS_ADDR  in  ADDR_W  bus address
BUS_WE  in  1  1 = write cycle, 0 = read cycle
BUSY  out  1  high while the clear sweep runs

Behaviour:
- Interface: one clock (CLK). RESET is asynchronous and active-high.
- Window hit: BUS_ADDR[ADDR_W-1:RAM_ADDR_W] == BASE_ADDR[ADDR_W-1:RAM_ADDR_W]. Offset = BUS_ADDR[RAM_ADDR_W-1:0].
- Ctrl hit: BUS_ADDR == CTRL_ADDR.
- FSM has two states:
  - CLEAR: mem[ptr] <= 0 each cycle, ptr <= ptr+1. When ptr == DEPTH-1, go to IDLE with ptr <= 0. The sweep lasts exactly DEPTH cycles.
  - IDLE: serves bus accesses. A write hit at CTRL_ADDR with BUS_DATA[0]=1 goes to CLEAR with ptr=0. A write with BUS_DATA[0]=0 has no effect.
- BUSY = (state == CLEAR). It is a registered state decode.
- Reset values: state=CLEAR, ptr=0, rd_data=0, oe=0, BUSY=1. The bus is high-Z. The array itself is not reset; after reset the sweep zero-fills it.
- Reset asserted mid-sweep or mid-access: immediate abort, back to the reset values, and the sweep restarts from entry 0.
- Write: at the rising edge with BUS_WE=1, window hit and state IDLE, mem[offset] <= BUS_DATA. The new value is visible to a read sampled on the next edge.
- Read: at the rising edge with BUS_WE=0 and a window hit in IDLE:
  - rd_data <= mem[offset], oe <= 1.
  - BUS_DATA = oe ? rd_data : 'z.
  - oe is high for exactly one cycle per sampled read hit; back-to-back reads give back-to-back driven cycles.
- Ctrl read (any state): rd_data <= {DATA_W-1 zeros, BUSY}, oe <= 1, same 1-cycle latency.
- During CLEAR:
  - Window writes are dropped.
  - Window reads leave oe=0, so the bus floats.
  - Ctrl writes are ignored; the sweep is not restarted.
- Miss (neither hit): oe <= 0 and no state change.
- Bus rule: the master must not drive BUS_DATA in the cycle after a sampled read. The block never drives when oe=0.
- Address wrap: offsets beyond DEPTH-1 cannot occur because the index is truncated. The ptr increment wraps to 0 only on the IDLE transition.
- Clear sweep and bus writes never collide: the array write port is muxed on state.

Decomposition:
- Package bus_ram_pkg:
  - state enum {CLEAR, IDLE}
  - CTRL_CLR_BIT = 0
  - STATUS_BUSY_BIT = 0
  - helper function for the window-hit compare
- Sub-module bus_ram_array:
  - single-port synchronous RAM: write-enable, index, write data, registered read data, parametrised by DATA_W and RAM_ADDR_W
  - infers block/distributed RAM
  - the top handles the FSM, decode, write mux and tri-state

Test Plan:
- Reset release, then poll CTRL_ADDR 8'hFF -> read returns 8'h01 until cycle 128 after release, then 8'h00. BUSY falls exactly 128 cycles after RESET deasserts.
- After the clear, write 8'h09 to 8'h03 and 8'hA5 to 8'h7F, then read 8'h03, 8'h7F, 8'h02 back-to-back -> BUS_DATA shows 8'h09, 8'hA5, 8'h00, each one cycle after its address is sampled. High-Z afterwards.
- Read 8'h80 (outside window) and write 8'h55 to 8'h80 -> BUS_DATA stays high-Z. A subsequent read of 8'h00 returns 8'h00 (no aliasing).
- Write 8'h01 to 8'hFF after memory is loaded -> BUSY=1 for 128 cycles:
  - a write of 8'h77 to 8'h10 during the sweep is dropped
  - a read of 8'h10 during the sweep floats the bus
  - after the sweep, 8'h10 and 8'h03 read 8'h00
- Assert RESET at sweep cycle 60 -> outputs return to their reset values immediately. After release, the sweep restarts and BUSY lasts a full 128 cycles.
- Write 8'h00 to 8'hFF in IDLE -> no sweep, BUSY stays 0, contents unchanged.
